// File: rtl/e203_ifu_bpupred_if.sv
// ---------------------------------------------------------------------------
// e203_ifu_bpupred_if
// Bundle between the IFU fetch / mini-decode side and the static branch
// predictor.
//   master : the IFU side. It drives the decoded instruction fields, the
//            IR/OITF hazard state, the regfile operands and flush. It
//            receives the prediction, bpu_wait and the regfile read request.
//   slave  : the predictor (e203_ifu_bpupred).
// ---------------------------------------------------------------------------
interface e203_ifu_bpupred_if #(
  parameter int PC_SIZE = 32,
  parameter int XLEN    = 32
);
  logic               dec_vld;
  logic [PC_SIZE-1:0] pc;
  logic               dec_rv32;
  logic               dec_jal;
  logic               dec_jalr;
  logic               dec_bxx;
  logic [XLEN-1:0]    dec_bjp_imm;
  logic [4:0]         dec_jalr_rs1idx;
  logic [4:0]         dec_rdidx;
  logic               ir_valid;
  logic               ir_rdwen;
  logic [4:0]         ir_rdidx;
  logic               oitf_empty;
  logic [XLEN-1:0]    rf2bpu_x1;
  logic [XLEN-1:0]    rf2bpu_rs1;
  logic               flush;
  logic               bpu_wait;
  logic               bpu2rf_rs1_ena;
  logic               prdt_taken;
  logic [PC_SIZE-1:0] prdt_pc;

  modport master (
    output dec_vld, pc, dec_rv32, dec_jal, dec_jalr, dec_bxx, dec_bjp_imm,
           dec_jalr_rs1idx, dec_rdidx, ir_valid, ir_rdwen, ir_rdidx,
           oitf_empty, rf2bpu_x1, rf2bpu_rs1, flush,
    input  bpu_wait, bpu2rf_rs1_ena, prdt_taken, prdt_pc
  );

  modport slave (
    input  dec_vld, pc, dec_rv32, dec_jal, dec_jalr, dec_bxx, dec_bjp_imm,
           dec_jalr_rs1idx, dec_rdidx, ir_valid, ir_rdwen, ir_rdidx,
           oitf_empty, rf2bpu_x1, rf2bpu_rs1, flush,
    output bpu_wait, bpu2rf_rs1_ena, prdt_taken, prdt_pc
  );
endinterface

// File: rtl/e203_ifu_bpupred.sv
// ---------------------------------------------------------------------------
// e203_ifu_bpupred
// Static branch predictor with a return-address stack, placed directly after
// the IFU mini-decoder.
//   - jal        : always taken, target pc+imm
//   - bxx        : taken when the offset is negative (backward), target pc+imm
//   - jalr       : always taken, target (base+imm) with bit0 cleared, where
//                  the base comes from x0, the RAS, x1 or the regfile read port
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bpu        : slave side of e203_ifu_bpupred_if. It carries the decode
//                fields, the IR/OITF hazard inputs, the regfile operands and
//                flush in, and bpu_wait, bpu2rf_rs1_ena, prdt_taken and
//                prdt_pc out.
// ---------------------------------------------------------------------------
module e203_ifu_bpupred #(
  parameter int PC_SIZE   = 32,
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  e203_ifu_bpupred_if.slave bpu
);

  localparam int              RAS_AW   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [RAS_AW:0] RAS_FULL = (RAS_AW + 1)'(RAS_DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DEP = 2'd1,
    RD_RF    = 2'd2
  } state_t;

  state_t              state_reg, state_next;

  // RAS storage is circular. ras_ptr_reg is the next slot to write, so the
  // top entry sits at ras_ptr_reg-1. When the stack is full, a push
  // overwrites the oldest entry.
  logic [PC_SIZE-1:0]  ras_mem [RAS_DEPTH];
  logic [RAS_AW-1:0]   ras_ptr_reg, ras_ptr_next;
  logic [RAS_AW:0]     ras_cnt_reg, ras_cnt_next;
  logic                ras_wr_en;
  logic [RAS_AW-1:0]   ras_wr_idx;
  logic [RAS_AW-1:0]   ras_top_idx;
  logic [PC_SIZE-1:0]  ras_top;

  logic                rs1_x0, rs1_x1, rs1_link, rd_link;
  logic                ras_hit, jalr_x1, jalr_xn;
  logic                dep_x1, dep_xn;
  logic                wait_c, ena_c;
  logic                accept, push, pop;
  logic [PC_SIZE-1:0]  push_val;
  logic [XLEN-1:0]     jalr_base;
  logic [PC_SIZE-1:0]  jalr_sum, jalr_tgt, seq_tgt;
  logic                taken_raw;

  assign rs1_x0   = (bpu.dec_jalr_rs1idx == 5'd0);
  assign rs1_x1   = (bpu.dec_jalr_rs1idx == 5'd1);
  assign rs1_link = rs1_x1 | (bpu.dec_jalr_rs1idx == 5'd5);
  assign rd_link  = (bpu.dec_rdidx == 5'd1) | (bpu.dec_rdidx == 5'd5);

  assign ras_top_idx = ras_ptr_reg - RAS_AW'(1);
  assign ras_top     = ras_mem[ras_top_idx];

  // A RAS hit resolves the jalr target without reading any register, so it
  // takes priority over both the x1 path and the read-port path.
  assign ras_hit = bpu.dec_jalr & rs1_link & ~rd_link & (ras_cnt_reg != '0);
  assign jalr_x1 = bpu.dec_jalr & rs1_x1 & ~ras_hit;
  assign jalr_xn = bpu.dec_jalr & ~rs1_x0 & ~rs1_x1 & ~ras_hit;

  // x1 is read combinationally, so it only has to wait for an in-flight
  // writer of x1. The shared read port cannot be compared by index, so any
  // IR occupant counts as a hazard for it.
  assign dep_x1 = ~bpu.oitf_empty | (bpu.ir_valid & bpu.ir_rdwen & (bpu.ir_rdidx == 5'd1));
  assign dep_xn = ~bpu.oitf_empty | bpu.ir_valid;

  always_comb begin
    state_next = state_reg;
    wait_c     = 1'b0;
    ena_c      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (jalr_x1 && dep_x1) begin
          wait_c     = 1'b1;
          state_next = WAIT_DEP;
        end else if (jalr_xn) begin
          wait_c = 1'b1;
          if (dep_xn) begin
            state_next = WAIT_DEP;
          end else begin
            ena_c      = 1'b1;
            state_next = RD_RF;
          end
        end
      end
      WAIT_DEP: begin
        // Keep stalling in the cycle the hazard clears. The held instruction
        // is then evaluated again from IDLE.
        wait_c = 1'b1;
        if (rs1_x1 ? ~dep_x1 : ~dep_xn) begin
          state_next = IDLE;
        end
      end
      RD_RF: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Nothing can be pending without a valid instruction, and a flush cancels
    // whatever was outstanding.
    if (!bpu.dec_vld) begin
      wait_c     = 1'b0;
      ena_c      = 1'b0;
      state_next = IDLE;
    end
    if (bpu.flush) begin
      ena_c      = 1'b0;
      state_next = IDLE;
    end
  end

  // The read-port data is only meaningful in RD_RF, and bpu_wait masks the
  // prediction in every other cycle that would use it.
  assign jalr_base = rs1_x0 ? '0 : (rs1_x1 ? bpu.rf2bpu_x1 : bpu.rf2bpu_rs1);
  assign jalr_sum  = PC_SIZE'(jalr_base + bpu.dec_bjp_imm);
  assign jalr_tgt  = jalr_sum & ~PC_SIZE'(1);
  assign seq_tgt   = bpu.pc + bpu.dec_bjp_imm[PC_SIZE-1:0];
  assign taken_raw = bpu.dec_jal | bpu.dec_jalr | (bpu.dec_bxx & bpu.dec_bjp_imm[XLEN-1]);

  assign bpu.bpu_wait       = wait_c;
  assign bpu.bpu2rf_rs1_ena = ena_c;
  assign bpu.prdt_taken     = bpu.dec_vld & ~wait_c & taken_raw;
  assign bpu.prdt_pc        = ~bpu.dec_vld  ? '0 :
                              bpu.dec_jalr  ? (ras_hit ? ras_top : jalr_tgt) :
                                              seq_tgt;

  // RAS bookkeeping only advances on an instruction that really leaves decode.
  assign accept   = bpu.dec_vld & ~wait_c & ~bpu.flush;
  assign push     = accept & (bpu.dec_jal | bpu.dec_jalr) & rd_link;
  assign pop      = accept & ras_hit;
  assign push_val = bpu.pc + (bpu.dec_rv32 ? PC_SIZE'(4) : PC_SIZE'(2));

  always_comb begin
    ras_ptr_next = ras_ptr_reg;
    ras_cnt_next = ras_cnt_reg;
    ras_wr_en    = 1'b0;
    ras_wr_idx   = ras_ptr_reg;
    if (push && pop) begin
      // Return and call in one instruction: swap the top in place.
      ras_wr_en  = 1'b1;
      ras_wr_idx = ras_top_idx;
    end else if (push) begin
      ras_wr_en    = 1'b1;
      ras_ptr_next = ras_ptr_reg + RAS_AW'(1);
      if (ras_cnt_reg != RAS_FULL) begin
        ras_cnt_next = ras_cnt_reg + (RAS_AW + 1)'(1);
      end
    end else if (pop) begin
      ras_ptr_next = ras_top_idx;
      ras_cnt_next = ras_cnt_reg - (RAS_AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ras_ptr_reg <= '0;
      ras_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ras_ptr_reg <= ras_ptr_next;
      ras_cnt_reg <= ras_cnt_next;
    end
  end

  // Entries need no reset. ras_cnt_reg alone says which of them are live.
  always_ff @(posedge clk) begin
    if (rst_n && ras_wr_en) begin
      ras_mem[ras_wr_idx] <= push_val;
    end
  end

endmodule

// File: tb/tb_e203_ifu_bpupred.sv
module tb_e203_ifu_bpupred;

  localparam int K_OTHER = 0;
  localparam int K_JAL   = 1;
  localparam int K_JALR  = 2;
  localparam int K_BXX   = 3;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  e203_ifu_bpupred_if #(.PC_SIZE(32), .XLEN(32)) bus ();

  e203_ifu_bpupred #(.PC_SIZE(32), .XLEN(32), .RAS_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bpu   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #3;
  endtask

  task automatic deps(input logic oe, input logic iv, input logic iw, input logic [4:0] ri);
    bus.oitf_empty = oe;
    bus.ir_valid   = iv;
    bus.ir_rdwen   = iw;
    bus.ir_rdidx   = ri;
  endtask

  task automatic drive(input int kind, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [4:0] rs1, input logic [4:0] rd, input logic rv32);
    bus.dec_vld         = 1'b1;
    bus.pc              = pc;
    bus.dec_rv32        = rv32;
    bus.dec_jal         = (kind == K_JAL);
    bus.dec_jalr        = (kind == K_JALR);
    bus.dec_bxx         = (kind == K_BXX);
    bus.dec_bjp_imm     = imm;
    bus.dec_jalr_rs1idx = rs1;
    bus.dec_rdidx       = rd;
  endtask

  task automatic idle_in();
    drive(K_OTHER, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1);
    bus.dec_vld    = 1'b0;
    bus.flush      = 1'b0;
    bus.rf2bpu_x1  = 32'h0;
    bus.rf2bpu_rs1 = 32'h0;
    deps(1'b1, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic bit is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // Single-cycle vectors. None of them touch the RAS.
  typedef struct {
    logic        vld;
    int          kind;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic        exp_taken;
    logic        chk_pc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [8];

  logic [31:0] ras_q [$];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;

    vecs[0] = '{1'b1, K_BXX,   32'h0000_0100, 32'hFFFF_FFF8, 5'd0, 1'b1, 1'b1, 32'h0000_00F8};
    vecs[1] = '{1'b1, K_BXX,   32'h0000_0100, 32'h0000_0008, 5'd0, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{1'b1, K_JAL,   32'h0000_0400, 32'h0000_0020, 5'd0, 1'b1, 1'b1, 32'h0000_0420};
    vecs[3] = '{1'b1, K_JAL,   32'hFFFF_FFF0, 32'h0000_0020, 5'd0, 1'b1, 1'b1, 32'h0000_0010};
    vecs[4] = '{1'b1, K_JALR,  32'h0000_0800, 32'h0000_0123, 5'd0, 1'b1, 1'b1, 32'h0000_0122};
    vecs[5] = '{1'b1, K_OTHER, 32'h0000_0900, 32'hFFFF_FFF0, 5'd0, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b0, K_JAL,   32'h0000_0A00, 32'h0000_0040, 5'd0, 1'b0, 1'b1, 32'h0};
    vecs[7] = '{1'b1, K_BXX,   32'h0000_0000, 32'h8000_0000, 5'd0, 1'b1, 1'b1, 32'h8000_0000};

    do_reset();

    // Reset state with no valid instruction.
    sample();
    chk1("rst_wait", bus.bpu_wait, 1'b0);
    chk1("rst_ena", bus.bpu2rf_rs1_ena, 1'b0);
    chk1("rst_taken", bus.prdt_taken, 1'b0);
    chk32("rst_pc", bus.prdt_pc, 32'h0);
    advance();

    // Table of single-cycle predictions.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].kind, vecs[i].pc, vecs[i].imm, vecs[i].rs1, 5'd0, 1'b1);
      bus.dec_vld = vecs[i].vld;
      sample();
      chk1("vec_wait", bus.bpu_wait, 1'b0);
      chk1("vec_ena", bus.bpu2rf_rs1_ena, 1'b0);
      chk1("vec_taken", bus.prdt_taken, vecs[i].exp_taken);
      if (vecs[i].chk_pc) chk32("vec_pc", bus.prdt_pc, vecs[i].exp_pc);
      $display("vec %0d: kind=%0d pc=0x%08h imm=0x%08h -> taken=%0b pc=0x%08h",
               i, vecs[i].kind, vecs[i].pc, vecs[i].imm, bus.prdt_taken, bus.prdt_pc);
      advance();
    end

    // Call then return through the RAS, with an x1 hazard present that the
    // RAS path must ignore.
    do_reset();
    drive(K_JAL, 32'h200, 32'h40, 5'd0, 5'd1, 1'b1);
    sample();
    chk1("t2_call_taken", bus.prdt_taken, 1'b1);
    chk32("t2_call_pc", bus.prdt_pc, 32'h240);
    advance();
    drive(K_JALR, 32'h240, 32'h0, 5'd1, 5'd0, 1'b1);
    deps(1'b1, 1'b1, 1'b1, 5'd1);
    bus.rf2bpu_x1 = 32'hDEAD0;
    sample();
    chk1("t2_ret_wait", bus.bpu_wait, 1'b0);
    chk1("t2_ret_taken", bus.prdt_taken, 1'b1);
    chk32("t2_ret_pc", bus.prdt_pc, 32'h204);
    advance();
    drive(K_JALR, 32'h204, 32'h0, 5'd1, 5'd0, 1'b1);
    deps(1'b1, 1'b0, 1'b0, 5'd0);
    bus.rf2bpu_x1 = 32'h1000;
    sample();
    chk1("t2_empty_wait", bus.bpu_wait, 1'b0);
    chk32("t2_empty_pc", bus.prdt_pc, 32'h1000);
    advance();
    drive(K_JAL, 32'h300, 32'h4, 5'd0, 5'd1, 1'b0);
    sample();
    chk32("t2_c_call_pc", bus.prdt_pc, 32'h304);
    advance();
    drive(K_JALR, 32'h304, 32'h0, 5'd5, 5'd0, 1'b1);
    sample();
    chk1("t2_x5_ret_wait", bus.bpu_wait, 1'b0);
    chk32("t2_x5_ret_pc", bus.prdt_pc, 32'h302);
    advance();
    $display("seq t2: call/return via RAS done");

    // jalr x5 with an empty RAS goes through the read port.
    do_reset();
    drive(K_JALR, 32'h100, 32'h0, 5'd5, 5'd0, 1'b1);
    bus.rf2bpu_rs1 = 32'h301;
    sample();
    chk1("t3_issue_wait", bus.bpu_wait, 1'b1);
    chk1("t3_issue_ena", bus.bpu2rf_rs1_ena, 1'b1);
    advance();
    sample();
    chk1("t3_rd_wait", bus.bpu_wait, 1'b0);
    chk1("t3_rd_ena", bus.bpu2rf_rs1_ena, 1'b0);
    chk1("t3_rd_taken", bus.prdt_taken, 1'b1);
    chk32("t3_rd_pc", bus.prdt_pc, 32'h300);
    advance();
    $display("seq t3: read-port jalr done");

    // x1 hazard held in IR for 3 cycles.
    begin
      int k;
      drive(K_JALR, 32'h100, 32'h10, 5'd1, 5'd0, 1'b1);
      bus.rf2bpu_x1 = 32'h5000;
      deps(1'b1, 1'b1, 1'b1, 5'd1);
      for (int c = 0; c < 3; c++) begin
        sample();
        chk1("t4_dep_wait", bus.bpu_wait, 1'b1);
        chk1("t4_dep_ena", bus.bpu2rf_rs1_ena, 1'b0);
        advance();
      end
      deps(1'b1, 1'b0, 1'b0, 5'd0);
      for (k = 0; k < 5; k++) begin
        sample();
        if (!bus.bpu_wait) break;
        advance();
      end
      chk1("t4_wait_bounded", (k < 5), 1'b1);
      chk1("t4_taken", bus.prdt_taken, 1'b1);
      chk32("t4_pc", bus.prdt_pc, 32'h5010);
      advance();
      $display("seq t4: x1 hazard resolved after %0d extra cycles", k);
    end

    // Five calls into a four-deep RAS, then five returns.
    begin
      logic [31:0] exp_ret [5];
      exp_ret[0] = 32'h1404;
      exp_ret[1] = 32'h1304;
      exp_ret[2] = 32'h1204;
      exp_ret[3] = 32'h1104;
      exp_ret[4] = 32'hABC8;
      do_reset();
      for (int i = 0; i < 5; i++) begin
        drive(K_JAL, 32'h1000 + 32'(i) * 32'h100, 32'h10, 5'd0, 5'd1, 1'b1);
        sample();
        chk32("t5_call_pc", bus.prdt_pc, 32'h1010 + 32'(i) * 32'h100);
        advance();
      end
      bus.rf2bpu_x1 = 32'hABC0;
      for (int i = 0; i < 5; i++) begin
        drive(K_JALR, 32'h2000, 32'h8, 5'd1, 5'd0, 1'b1);
        sample();
        chk1("t5_ret_wait", bus.bpu_wait, 1'b0);
        chk32("t5_ret_pc", bus.prdt_pc, exp_ret[i]);
        $display("seq t5: return %0d -> 0x%08h", i, bus.prdt_pc);
        advance();
      end
    end

    // Flush on the issue cycle, during RD_RF and during WAIT_DEP.
    do_reset();
    drive(K_JALR, 32'h100, 32'h0, 5'd7, 5'd0, 1'b1);
    bus.rf2bpu_rs1 = 32'h900;
    bus.flush = 1'b1;
    sample();
    chk1("t6_flush_issue_ena", bus.bpu2rf_rs1_ena, 1'b0);
    advance();
    bus.flush = 1'b0;
    sample();
    chk1("t6_reissue_wait", bus.bpu_wait, 1'b1);
    chk1("t6_reissue_ena", bus.bpu2rf_rs1_ena, 1'b1);
    advance();
    bus.flush = 1'b1;
    sample();
    chk1("t6_flush_rd_ena", bus.bpu2rf_rs1_ena, 1'b0);
    chk1("t6_flush_rd_wait", bus.bpu_wait, 1'b0);
    advance();
    bus.flush = 1'b0;
    sample();
    chk1("t6_after_rd_wait", bus.bpu_wait, 1'b1);
    chk1("t6_after_rd_ena", bus.bpu2rf_rs1_ena, 1'b1);
    advance();
    sample();
    chk32("t6_after_rd_pc", bus.prdt_pc, 32'h900);
    advance();
    drive(K_JALR, 32'h100, 32'h0, 5'd1, 5'd0, 1'b1);
    deps(1'b0, 1'b0, 1'b0, 5'd0);
    sample();
    chk1("t6_dep_wait", bus.bpu_wait, 1'b1);
    advance();
    bus.flush = 1'b1;
    sample();
    chk1("t6_flush_dep_wait", bus.bpu_wait, 1'b1);
    advance();
    bus.flush = 1'b0;
    drive(K_BXX, 32'h700, 32'hFFFF_FFFC, 5'd0, 5'd0, 1'b1);
    sample();
    chk1("t6_post_flush_wait", bus.bpu_wait, 1'b0);
    chk32("t6_post_flush_pc", bus.prdt_pc, 32'h6FC);
    advance();
    $display("seq t6: flush cases done");

    // Reset while in WAIT_DEP with one RAS entry live.
    deps(1'b1, 1'b0, 1'b0, 5'd0);
    drive(K_JAL, 32'h600, 32'h20, 5'd0, 5'd1, 1'b1);
    advance();
    drive(K_JALR, 32'h620, 32'h0, 5'd1, 5'd1, 1'b1);
    deps(1'b1, 1'b1, 1'b1, 5'd1);
    sample();
    chk1("t6r_dep_wait", bus.bpu_wait, 1'b1);
    advance();
    rst_n = 1'b0;
    advance();
    rst_n = 1'b1;
    drive(K_BXX, 32'h700, 32'hFFFF_FFFC, 5'd0, 5'd0, 1'b1);
    sample();
    chk1("t6r_post_rst_wait", bus.bpu_wait, 1'b0);
    chk32("t6r_post_rst_pc", bus.prdt_pc, 32'h6FC);
    advance();
    drive(K_JALR, 32'h704, 32'h0, 5'd1, 5'd0, 1'b1);
    deps(1'b1, 1'b0, 1'b0, 5'd0);
    bus.rf2bpu_x1 = 32'h7770;
    sample();
    chk1("t6r_ras_empty_wait", bus.bpu_wait, 1'b0);
    chk32("t6r_ras_empty_pc", bus.prdt_pc, 32'h7770);
    advance();
    $display("seq t6r: reset during WAIT_DEP done");

    // Random instruction stream against a reference model. RAS is a queue;
    // stall timing follows the documented rules.
    do_reset();
    ras_q.delete();
    for (int n = 0; n < 300; n++) begin
      int          kind;
      logic [31:0] pc, imm;
      logic [4:0]  rs1, rd;
      logic        rv32;
      bit          read_pending, dep_pending, done;
      int          cyc;

      kind = $urandom_range(0, 3);
      pc   = $urandom & 32'hFFFF_FFFE;
      imm  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed(12'($urandom)));
      rv32 = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rs1 = 5'd0;
        1: rs1 = 5'd1;
        2: rs1 = 5'd5;
        default: rs1 = 5'($urandom_range(2, 31));
      endcase
      case ($urandom_range(0, 3))
        0: rd = 5'd0;
        1: rd = 5'd1;
        2: rd = 5'd5;
        default: rd = 5'($urandom_range(0, 31));
      endcase

      if ($urandom_range(0, 7) == 0) begin
        drive(kind, pc, imm, rs1, rd, rv32);
        bus.dec_vld = 1'b0;
        sample();
        chk1("rnd_gap_wait", bus.bpu_wait, 1'b0);
        chk1("rnd_gap_ena", bus.bpu2rf_rs1_ena, 1'b0);
        chk1("rnd_gap_taken", bus.prdt_taken, 1'b0);
        chk32("rnd_gap_pc", bus.prdt_pc, 32'h0);
        advance();
      end

      drive(kind, pc, imm, rs1, rd, rv32);
      read_pending = 0;
      dep_pending  = 0;
      done         = 0;
      for (cyc = 0; cyc < 40; cyc++) begin
        bit          dx1, dxn, hit, ew, eena, etaken, cleared;
        logic [31:0] base, epc;
        bus.oitf_empty = ($urandom_range(0, 9) != 0);
        bus.ir_valid   = ($urandom_range(0, 3) == 0);
        bus.ir_rdwen   = 1'($urandom_range(0, 1));
        bus.ir_rdidx   = 5'($urandom_range(0, 2));
        bus.rf2bpu_x1  = $urandom;
        bus.rf2bpu_rs1 = $urandom;

        dx1  = !bus.oitf_empty || (bus.ir_valid && bus.ir_rdwen && bus.ir_rdidx == 5'd1);
        dxn  = !bus.oitf_empty || bus.ir_valid;
        hit  = (kind == K_JALR) && is_link(rs1) && !is_link(rd) && (ras_q.size() > 0);
        ew   = 0;
        eena = 0;
        cleared = 0;
        base = 32'h0;
        epc  = pc + imm;
        etaken = (kind == K_JAL) || (kind == K_JALR) || (kind == K_BXX && imm[31]);
        if (kind == K_JALR) begin
          if (read_pending) begin
            base = bus.rf2bpu_rs1;
          end else if (dep_pending) begin
            ew = 1;
            cleared = (rs1 == 5'd1) ? !dx1 : !dxn;
          end else if (rs1 == 5'd0) begin
            base = 32'h0;
          end else if (hit) begin
            base = 32'h0;
          end else if (rs1 == 5'd1) begin
            ew = dx1;
            base = bus.rf2bpu_x1;
          end else begin
            ew = 1;
            eena = !dxn;
          end
          epc = hit && !read_pending ? ras_q[ras_q.size() - 1] : ((base + imm) & 32'hFFFF_FFFE);
        end

        sample();
        chk1("rnd_wait", bus.bpu_wait, ew);
        chk1("rnd_ena", bus.bpu2rf_rs1_ena, eena);
        if (!ew) begin
          chk1("rnd_taken", bus.prdt_taken, etaken);
          if (etaken) chk32("rnd_pc", bus.prdt_pc, epc);
        end
        advance();

        if (read_pending) begin
          read_pending = 0;
        end else if (dep_pending) begin
          if (cleared) dep_pending = 0;
        end else if (ew) begin
          if (eena) read_pending = 1;
          else      dep_pending  = 1;
        end
        if (!ew) begin
          bit push;
          push = ((kind == K_JAL) || (kind == K_JALR)) && is_link(rd);
          if (push && hit) begin
            ras_q[ras_q.size() - 1] = pc + (rv32 ? 32'd4 : 32'd2);
          end else if (push) begin
            ras_q.push_back(pc + (rv32 ? 32'd4 : 32'd2));
            if (ras_q.size() > 4) void'(ras_q.pop_front());
          end else if (hit) begin
            void'(ras_q.pop_back());
          end
          done = 1;
          break;
        end
      end
      chk1("rnd_accept_bound", done, 1'b1);
      $display("rnd %0d: kind=%0d pc=0x%08h rs1=%0d rd=%0d cycles=%0d ras=%0d",
               n, kind, pc, rs1, rd, cyc + 1, ras_q.size());
    end

    idle_in();
    advance();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
